// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared
// single-port synchronous RAM.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_ack;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 1-cycle synchronous RAM.
// Each access takes IDLE -> ACCESS -> RESP; the ack pulses in RESP.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t                r_state;
    state_t                w_next_state;
    logic                  w_grant_valid;
    logic                  w_grant_owner;
    logic                  w_start;
    logic                  w_f_read_resp;
    logic                  w_d_read_resp;

    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic                  r_f_ack;
    logic                  r_d_ack;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_f_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decision; on a tie the port not served last wins.
    always_comb begin
        w_next_state  = r_state;
        w_grant_valid = 1'b0;
        w_grant_owner = OWNER_F;
        case (r_state)
            IDLE: begin
                if (bus.f_req && bus.d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_owner = ~r_last_owner;
                end else if (bus.f_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_owner = OWNER_F;
                end else if (bus.d_req) begin
                    w_grant_valid = 1'b1;
                    w_grant_owner = OWNER_D;
                end else begin
                    w_grant_valid = 1'b0;
                    w_grant_owner = OWNER_F;
                end
                if (w_grant_valid) begin
                    w_next_state = ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_start       = (r_state == IDLE) && w_grant_valid;
    assign w_f_read_resp = (r_state == RESP) && (r_owner == OWNER_F) && !r_we;
    assign w_d_read_resp = (r_state == RESP) && (r_owner == OWNER_D) && !r_we;

    // Transaction latch, RAM strobes, ack pulses and per-port read-data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWNER_F;
            r_last_owner <= OWNER_D;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_f_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_busy       <= 1'b0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_f_ack  <= 1'b0;
            r_d_ack  <= 1'b0;
            r_busy   <= (w_next_state != IDLE);
            if (w_start) begin
                r_owner      <= w_grant_owner;
                r_last_owner <= w_grant_owner;
                r_mem_en     <= 1'b1;
                if (w_grant_owner == OWNER_D) begin
                    r_we     <= bus.d_we;
                    r_addr   <= bus.d_addr;
                    r_wdata  <= bus.d_wdata;
                    r_mem_we <= bus.d_we;
                end else begin
                    r_we     <= 1'b0;
                    r_addr   <= bus.f_addr;
                    r_wdata  <= '0;
                    r_mem_we <= 1'b0;
                end
            end else if (r_state == ACCESS) begin
                r_f_ack <= (r_owner == OWNER_F);
                r_d_ack <= (r_owner == OWNER_D);
            end else if (w_f_read_resp) begin
                r_f_rdata <= bus.mem_rdata;
            end else if (w_d_read_resp) begin
                r_d_rdata <= bus.mem_rdata;
            end
        end
    end

    // Strobes are gated by rst so a reset during ACCESS never touches the RAM.
    assign bus.mem_en    = r_mem_en & ~rst;
    assign bus.mem_we    = r_mem_we & ~rst;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.f_ack     = r_f_ack;
    assign bus.d_ack     = r_d_ack;
    assign bus.busy      = r_busy;
    // Read data arrives from the RAM during RESP, so it bypasses the hold register then.
    assign bus.f_rdata   = w_f_read_resp ? bus.mem_rdata : r_f_rdata;
    assign bus.d_rdata   = w_d_read_resp ? bus.mem_rdata : r_d_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a slot-schedule reference model predicts
// every output cycle by cycle; directed scenarios cover the named sequences.
module tb_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_req = 1'b1;

    logic          pre_we   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] ram [0:2047];
    logic [DW-1:0] ram_q;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural 1-cycle synchronous single-port RAM.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_q <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_q;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Requester state, index 0 = fetch, 1 = data.
    bit            act  [0:1];
    bit            gnt  [0:1];
    bit            drop [0:1];
    bit            cool [0:1];
    bit            rq   [0:1];
    bit            rwe  [0:1];
    logic [AW-1:0] raddr[0:1];
    logic [DW-1:0] rwd  [0:1];
    int            mode [0:1];

    // Reference model: scheduled slot cycles plus a shadow memory.
    logic [DW-1:0] m_mem [0:2047];
    int            m_en_c  = -1;
    int            m_ack_c = -1;
    int            m_free  = 0;
    bit            m_last  = 1'b1;
    bit            m_own   = 1'b0;
    bit            m_we    = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wd    = '0;
    logic [DW-1:0] m_f_hold = '0;
    logic [DW-1:0] m_d_hold = '0;

    bit tie_log = 1'b0;
    int tie_t0  = 0;
    int tie_n   = 0;
    int tie_c [0:3];
    int tie_p [0:3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (cool[p]) begin
                rq[p]   = 1'b0;
                cool[p] = 1'b0;
            end else if (act[p]) begin
                if (gnt[p] && mode[p] == 1) begin
                    if ($urandom_range(0, 7) == 0) drop[p] = 1'b1;
                    raddr[p] = AW'($urandom);
                    rwd[p]   = DW'($urandom);
                    rwe[p]   = (p == 1) ? 1'($urandom) : 1'b0;
                end
                rq[p] = !drop[p];
            end else if (mode[p] == 2 || (mode[p] == 1 && $urandom_range(0, 2) != 0)) begin
                act[p]   = 1'b1;
                gnt[p]   = 1'b0;
                drop[p]  = 1'b0;
                rq[p]    = 1'b1;
                rwe[p]   = (p == 1) && ($urandom_range(0, 1) == 1);
                raddr[p] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 31)) : AW'($urandom);
                rwd[p]   = DW'($urandom);
            end else begin
                rq[p] = 1'b0;
            end
        end
        rst         = rst_req;
        bus.f_req   = rq[0];
        bus.f_addr  = raddr[0];
        bus.d_req   = rq[1];
        bus.d_we    = rwe[1];
        bus.d_addr  = raddr[1];
        bus.d_wdata = rwd[1];
    endtask

    task automatic check_cycle();
        bit            exp_en;
        logic [DW-1:0] exp_f;
        logic [DW-1:0] exp_d;
        exp_en = (cyc == m_en_c) && !rst;
        check_eq("mem_en", 32'(bus.mem_en), 32'(exp_en));
        check_eq("mem_we", 32'(bus.mem_we), 32'(exp_en && m_we));
        if (exp_en) begin
            check_eq("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            if (m_we) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
        end
        check_eq("f_ack", 32'(bus.f_ack), 32'((cyc == m_ack_c) && m_own == 1'b0));
        check_eq("d_ack", 32'(bus.d_ack), 32'((cyc == m_ack_c) && m_own == 1'b1));
        check_eq("busy", 32'(bus.busy), 32'((m_en_c >= 0) && cyc >= m_en_c && cyc <= m_ack_c));
        exp_f = (cyc == m_ack_c && m_own == 1'b0 && !m_we) ? m_mem[m_addr] : m_f_hold;
        exp_d = (cyc == m_ack_c && m_own == 1'b1 && !m_we) ? m_mem[m_addr] : m_d_hold;
        check_eq("f_rdata", 32'(bus.f_rdata), 32'(exp_f));
        check_eq("d_rdata", 32'(bus.d_rdata), 32'(exp_d));
        if (tie_log && (bus.f_ack || bus.d_ack) && tie_n < 4) begin
            tie_c[tie_n] = cyc - tie_t0;
            tie_p[tie_n] = bus.d_ack ? 1 : 0;
            tie_n++;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_en_c   = -1;
            m_ack_c  = -1;
            m_free   = cyc + 1;
            m_last   = 1'b1;
            m_f_hold = '0;
            m_d_hold = '0;
            for (int p = 0; p < 2; p++) begin
                act[p]  = 1'b0;
                cool[p] = 1'b0;
            end
        end else begin
            if (cyc == m_en_c && m_we) m_mem[m_addr] = m_wd;
            if (cyc == m_ack_c) begin
                if (!m_we) begin
                    if (m_own == 1'b0) m_f_hold = m_mem[m_addr];
                    else               m_d_hold = m_mem[m_addr];
                end
                act[m_own]  = 1'b0;
                cool[m_own] = 1'b1;
            end
            if (cyc >= m_free && (rq[0] || rq[1])) begin
                m_own   = (rq[0] && rq[1]) ? !m_last : !rq[0];
                m_last  = m_own;
                m_we    = (m_own == 1'b1) ? rwe[1] : 1'b0;
                m_addr  = raddr[m_own];
                m_wd    = rwd[m_own];
                m_en_c  = cyc + 1;
                m_ack_c = cyc + 2;
                m_free  = cyc + 3;
                gnt[m_own] = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic step();
        drive();
        #1;
        check_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic start_req(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        act[p] = 1'b1; gnt[p] = 1'b0; drop[p] = 1'b0; cool[p] = 1'b0;
        rwe[p] = we; raddr[p] = a; rwd[p] = d;
    endtask

    initial begin
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0; gnt[p] = 1'b0; drop[p] = 1'b0; cool[p] = 1'b0; rq[p] = 1'b0;
            rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0; mode[p] = 0;
        end
        bus.f_req = 1'b0; bus.f_addr = '0; bus.d_req = 1'b0;
        bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 2048; i++) begin
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 5) ? 16'hBEEF : DW'($urandom);
            m_mem[i] = pre_data;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst_acks", 32'({bus.f_ack, bus.d_ack}), 32'd0);
        check_eq("rst_rdata", 32'({bus.f_rdata, bus.d_rdata}), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);

        // Fetch read of a preloaded word.
        rst_req = 1'b0;
        start_req(0, 1'b0, 11'h005, 16'h0000);
        repeat (4) step();
        check_eq("fetch_beef", 32'(bus.f_rdata), 32'h0000BEEF);

        // Data write to the top address, then read it back.
        start_req(1, 1'b1, 11'h7FF, 16'h1234);
        repeat (4) step();
        start_req(1, 1'b0, 11'h7FF, 16'h0000);
        repeat (4) step();
        check_eq("rd_after_wr", 32'(bus.d_rdata), 32'h00001234);

        // Continuous tie after reset: F, D, F, D at +2, +5, +8, +11.
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        mode[0] = 2; mode[1] = 2;
        tie_t0  = cyc;
        tie_log = 1'b1;
        repeat (13) step();
        tie_log = 1'b0;
        mode[0] = 0; mode[1] = 0;
        repeat (3) step();
        check_eq("tie_count", 32'(tie_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("tie_ack_cycle", 32'(tie_c[i]), 32'(2 + 3 * i));
            check_eq("tie_ack_port", 32'(tie_p[i]), 32'(i % 2));
        end

        // Reset during the ACCESS cycle of a data write, then a tie.
        start_req(1, 1'b1, 11'h0AA, 16'h5A5A);
        step();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        check_eq("midop_rst_busy", 32'(bus.busy), 32'd0);
        start_req(0, 1'b0, 11'h011, 16'h0000);
        start_req(1, 1'b0, 11'h022, 16'h0000);
        step();
        check_eq("post_rst_tie_fetch", 32'(bus.mem_addr), 32'h011);
        repeat (8) step();
        start_req(1, 1'b0, 11'h0AA, 16'h0000);
        repeat (4) step();

        // Randomized traffic with occasional resets.
        mode[0] = 1; mode[1] = 1;
        for (int i = 0; i < 3000; i++) begin
            rst_req = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
